// File: rtl/risc_controller_mc.sv
// Multi-cycle RISC controller: instruction fetch, decode, ALU/MOV execution, LDR/STR with a
// memory ready handshake, HALT and a memory-timeout trap. Outputs decode from the state only.
module risc_controller_mc #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int ILLEGAL_TRAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       mem_ready,
  output logic [1:0] mem_cmd,
  output logic       addr_sel,
  output logic       load_addr,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       write,
  output logic [1:0] vsel,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       halted,
  output logic       error
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GETA, S_GETB, S_SHIFT, S_ALU, S_STAT,
    S_WRD, S_ADDR, S_LADDR, S_MRD, S_WMEM, S_STB, S_STC, S_MWR, S_HALT, S_ERR
  } state_t;

  state_t           state;
  state_t           state_next;
  state_t           illegal_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             in_wait;
  logic             timed_out;

  // The counter only runs while a wait state is stalled, so any entry into a wait state starts at 0.
  assign illegal_next = (ILLEGAL_TRAP != 0) ? S_ERR : S_IF1;
  assign in_wait      = (state == S_IF1) || (state == S_MRD) || (state == S_MWR);
  assign timed_out    = (MEM_TIMEOUT > 0) && in_wait && !mem_ready && (cnt == CNT_LAST);
  assign cnt_next     = (in_wait && !mem_ready) ? cnt + 1'b1 : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RST;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RST:   state_next = S_IF1;
      S_IF1:   if (mem_ready) state_next = S_IF2;
               else if (timed_out) state_next = S_ERR;
      S_IF2:   state_next = S_UPC;
      S_UPC:   state_next = S_DEC;
      S_DEC: begin
        case (opcode)
          3'b110:         state_next = (op == 2'b10) ? S_WIMM :
                                       (op == 2'b00) ? S_GETB : illegal_next;
          3'b101:         state_next = (op == 2'b11) ? S_GETB : S_GETA;
          3'b011, 3'b100: state_next = (op == 2'b00) ? S_GETA : illegal_next;
          3'b111:         state_next = (op == 2'b00) ? S_HALT : illegal_next;
          default:        state_next = illegal_next;
        endcase
      end
      S_WIMM:  state_next = S_IF1;
      S_GETA:  state_next = (opcode == 3'b101) ? S_GETB : S_ADDR;
      // GETB is shared by MOV reg, MVN (shift path), CMP (status only) and ADD/AND.
      S_GETB: begin
        if (opcode == 3'b110 || op == 2'b11) state_next = S_SHIFT;
        else if (op == 2'b01)                state_next = S_STAT;
        else                                 state_next = S_ALU;
      end
      S_SHIFT: state_next = S_WRD;
      S_ALU:   state_next = S_WRD;
      S_STAT:  state_next = S_IF1;
      S_WRD:   state_next = S_IF1;
      S_ADDR:  state_next = S_LADDR;
      S_LADDR: state_next = (opcode == 3'b011) ? S_MRD : S_STB;
      S_MRD:   if (mem_ready) state_next = S_WMEM;
               else if (timed_out) state_next = S_ERR;
      S_WMEM:  state_next = S_IF1;
      S_STB:   state_next = S_STC;
      S_STC:   state_next = S_MWR;
      S_MWR:   if (mem_ready) state_next = S_IF1;
               else if (timed_out) state_next = S_ERR;
      S_HALT:  state_next = S_HALT;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

  always_comb begin
    mem_cmd   = 2'b00;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    write     = 1'b0;
    vsel      = 2'b00;
    nsel      = 3'b000;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    halted    = 1'b0;
    error     = 1'b0;
    case (state)
      S_RST:   begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF1:   begin mem_cmd = 2'b01; addr_sel = 1'b1; end
      S_IF2:   begin mem_cmd = 2'b01; addr_sel = 1'b1; load_ir = 1'b1; end
      S_UPC:   load_pc = 1'b1;
      S_WIMM:  begin write = 1'b1; vsel = 2'b10; nsel = 3'b001; end
      S_GETA:  begin loada = 1'b1; nsel = 3'b001; end
      S_GETB:  begin loadb = 1'b1; nsel = 3'b100; end
      S_SHIFT: begin asel = 1'b1; loadc = 1'b1; end
      S_ALU:   loadc = 1'b1;
      S_STAT:  loads = 1'b1;
      S_WRD:   begin write = 1'b1; vsel = 2'b00; nsel = 3'b010; end
      S_ADDR:  begin bsel = 1'b1; loadc = 1'b1; end
      S_LADDR: load_addr = 1'b1;
      S_MRD:   mem_cmd = 2'b01;
      S_WMEM:  begin write = 1'b1; vsel = 2'b11; nsel = 3'b010; mem_cmd = 2'b01; end
      S_STB:   begin loadb = 1'b1; nsel = 3'b010; end
      S_STC:   begin asel = 1'b1; loadc = 1'b1; end
      S_MWR:   mem_cmd = 2'b10;
      S_HALT:  halted = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc_controller_mc.sv
// Scoreboard bench for risc_controller_mc: expected states are queued as stimulus is driven and
// popped after each clock edge, then their output decode is compared against the DUT outputs.
module tb_risc_controller_mc;

  typedef enum {
    T_RST, T_IF1, T_IF2, T_UPC, T_DEC, T_WIMM, T_GETA, T_GETB, T_SHIFT, T_ALU, T_STAT,
    T_WRD, T_ADDR, T_LADDR, T_MRD, T_WMEM, T_STB, T_STC, T_MWR, T_HALT, T_ERR
  } st_e;

  typedef struct packed {
    logic [1:0] mem_cmd;
    logic       addr_sel, load_addr, load_ir, load_pc, reset_pc, write;
    logic [1:0] vsel;
    logic [2:0] nsel;
    logic       loada, loadb, loadc, loads, asel, bsel, halted, error;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_ready;

  logic [1:0] mem_cmd_a, vsel_a, mem_cmd_b, vsel_b;
  logic [2:0] nsel_a, nsel_b;
  logic addr_sel_a, load_addr_a, load_ir_a, load_pc_a, reset_pc_a, write_a;
  logic loada_a, loadb_a, loadc_a, loads_a, asel_a, bsel_a, halted_a, error_a;
  logic addr_sel_b, load_addr_b, load_ir_b, load_pc_b, reset_pc_b, write_b;
  logic loada_b, loadb_b, loadc_b, loads_b, asel_b, bsel_b, halted_b, error_b;

  int  total = 0;
  int  bad   = 0;
  st_e exp_q[$];

  always #5 clk = ~clk;

  risc_controller_mc #(.MEM_TIMEOUT(4), .ILLEGAL_TRAP(0)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .mem_ready(mem_ready),
    .mem_cmd(mem_cmd_a), .addr_sel(addr_sel_a), .load_addr(load_addr_a), .load_ir(load_ir_a),
    .load_pc(load_pc_a), .reset_pc(reset_pc_a), .write(write_a), .vsel(vsel_a), .nsel(nsel_a),
    .loada(loada_a), .loadb(loadb_a), .loadc(loadc_a), .loads(loads_a), .asel(asel_a),
    .bsel(bsel_a), .halted(halted_a), .error(error_a)
  );

  risc_controller_mc #(.MEM_TIMEOUT(16), .ILLEGAL_TRAP(1)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .mem_ready(mem_ready),
    .mem_cmd(mem_cmd_b), .addr_sel(addr_sel_b), .load_addr(load_addr_b), .load_ir(load_ir_b),
    .load_pc(load_pc_b), .reset_pc(reset_pc_b), .write(write_b), .vsel(vsel_b), .nsel(nsel_b),
    .loada(loada_b), .loadb(loadb_b), .loadc(loadc_b), .loads(loads_b), .asel(asel_b),
    .bsel(bsel_b), .halted(halted_b), .error(error_b)
  );

  function automatic outs_t pack_a();
    return {mem_cmd_a, addr_sel_a, load_addr_a, load_ir_a, load_pc_a, reset_pc_a, write_a,
            vsel_a, nsel_a, loada_a, loadb_a, loadc_a, loads_a, asel_a, bsel_a, halted_a, error_a};
  endfunction

  function automatic outs_t pack_b();
    return {mem_cmd_b, addr_sel_b, load_addr_b, load_ir_b, load_pc_b, reset_pc_b, write_b,
            vsel_b, nsel_b, loada_b, loadb_b, loadc_b, loads_b, asel_b, bsel_b, halted_b, error_b};
  endfunction

  // Required output pattern for each controller state.
  function automatic outs_t outs(st_e s);
    outs_t o;
    o = '0;
    case (s)
      T_RST:   begin o.reset_pc = 1'b1; o.load_pc = 1'b1; end
      T_IF1:   begin o.mem_cmd = 2'b01; o.addr_sel = 1'b1; end
      T_IF2:   begin o.mem_cmd = 2'b01; o.addr_sel = 1'b1; o.load_ir = 1'b1; end
      T_UPC:   o.load_pc = 1'b1;
      T_WIMM:  begin o.write = 1'b1; o.vsel = 2'b10; o.nsel = 3'b001; end
      T_GETA:  begin o.loada = 1'b1; o.nsel = 3'b001; end
      T_GETB:  begin o.loadb = 1'b1; o.nsel = 3'b100; end
      T_SHIFT: begin o.asel = 1'b1; o.loadc = 1'b1; end
      T_ALU:   o.loadc = 1'b1;
      T_STAT:  o.loads = 1'b1;
      T_WRD:   begin o.write = 1'b1; o.nsel = 3'b010; end
      T_ADDR:  begin o.bsel = 1'b1; o.loadc = 1'b1; end
      T_LADDR: o.load_addr = 1'b1;
      T_MRD:   o.mem_cmd = 2'b01;
      T_WMEM:  begin o.write = 1'b1; o.vsel = 2'b11; o.nsel = 3'b010; o.mem_cmd = 2'b01; end
      T_STB:   begin o.loadb = 1'b1; o.nsel = 3'b010; end
      T_STC:   begin o.asel = 1'b1; o.loadc = 1'b1; end
      T_MWR:   o.mem_cmd = 2'b10;
      T_HALT:  o.halted = 1'b1;
      T_ERR:   o.error = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic drive(input bit mr, input st_e exp);
    mem_ready = mr;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; opcode = 3'b000; op = 2'b00; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (pack_a() !== outs(T_RST)) begin
        bad++; $display("[TB] FAIL reset_a cycle %0d: got %h want %h", i, pack_a(), outs(T_RST));
      end
      total++;
      if (pack_b() !== outs(T_RST)) begin
        bad++; $display("[TB] FAIL reset_b cycle %0d: got %h want %h", i, pack_b(), outs(T_RST));
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_mov_imm();
    st_e seq[$];
    st_e e;
    seq = '{T_IF1, T_IF2, T_UPC, T_DEC, T_WIMM, T_IF1};
    opcode = 3'b110; op = 2'b10;
    for (int i = 0; i < seq.size(); i++) begin
      drive(1'b1, seq[i]);
      e = exp_q.pop_front();
      total++;
      if (pack_a() !== outs(e)) begin
        bad++; $display("[TB] FAIL mov_imm step %0d (%s): got %h want %h", i, e.name(), pack_a(), outs(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    st_e        seq[$];
    logic [4:0] ins[$];
    st_e        e;
    // ADD, CMP, MVN, MOV reg, AND issued back to back with instant memory.
    ins = '{5'b101_00, 5'b101_01, 5'b101_11, 5'b110_00, 5'b101_10};
    seq = '{T_IF2, T_UPC, T_DEC, T_GETA, T_GETB, T_ALU, T_WRD, T_IF1,
            T_IF2, T_UPC, T_DEC, T_GETA, T_GETB, T_STAT, T_IF1,
            T_IF2, T_UPC, T_DEC, T_GETB, T_SHIFT, T_WRD, T_IF1,
            T_IF2, T_UPC, T_DEC, T_GETB, T_SHIFT, T_WRD, T_IF1,
            T_IF2, T_UPC, T_DEC, T_GETA, T_GETB, T_ALU, T_WRD, T_IF1};
    for (int i = 0; i < seq.size(); i++) begin
      if (seq[i] == T_IF2 && ins.size() > 0) {opcode, op} = ins.pop_front();
      drive(1'b1, seq[i]);
      e = exp_q.pop_front();
      total++;
      if (pack_a() !== outs(e)) begin
        bad++; $display("[TB] FAIL b2b step %0d (%s): got %h want %h", i, e.name(), pack_a(), outs(e));
      end
    end
  endtask

  task automatic test_ldr_wait();
    st_e seq[$];
    bit  mr[$];
    st_e e;
    seq = '{T_IF2, T_UPC, T_DEC, T_GETA, T_ADDR, T_LADDR, T_MRD, T_MRD, T_MRD, T_MRD, T_WMEM, T_IF1};
    mr  = '{1'b1,  1'b1,  1'b1,  1'b1,   1'b1,   1'b1,    1'b1,  1'b0,  1'b0,  1'b0,  1'b1,   1'b1};
    opcode = 3'b011; op = 2'b00;
    for (int i = 0; i < seq.size(); i++) begin
      drive(mr[i], seq[i]);
      e = exp_q.pop_front();
      total++;
      if (pack_a() !== outs(e)) begin
        bad++; $display("[TB] FAIL ldr_wait step %0d (%s): got %h want %h", i, e.name(), pack_a(), outs(e));
      end
    end
  endtask

  task automatic test_str_timeout();
    st_e seq[$];
    bit  mr[$];
    st_e e;
    seq = '{T_IF2, T_UPC, T_DEC, T_GETA, T_ADDR, T_LADDR, T_STB, T_STC, T_MWR,
            T_MWR, T_MWR, T_MWR, T_ERR, T_ERR, T_ERR};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 3'b100; op = 2'b00;
    for (int i = 0; i < seq.size(); i++) begin
      drive(mr[i], seq[i]);
      e = exp_q.pop_front();
      total++;
      if (pack_a() !== outs(e)) begin
        bad++; $display("[TB] FAIL str_timeout step %0d (%s): got %h want %h", i, e.name(), pack_a(), outs(e));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (pack_a() !== outs(T_RST)) begin
      bad++; $display("[TB] FAIL err_reset: got %h want %h", pack_a(), outs(T_RST));
    end
  endtask

  task automatic test_illegal();
    st_e seq[$];
    st_e e;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    seq = '{T_IF1, T_IF2, T_UPC, T_DEC, T_IF1};
    opcode = 3'b001; op = 2'b00;
    for (int i = 0; i < seq.size(); i++) begin
      drive(1'b1, seq[i]);
      e = exp_q.pop_front();
      total++;
      if (pack_a() !== outs(e)) begin
        bad++; $display("[TB] FAIL illegal_nop step %0d (%s): got %h want %h", i, e.name(), pack_a(), outs(e));
      end
    end
    total++;
    if (pack_b() !== outs(T_ERR)) begin
      bad++; $display("[TB] FAIL illegal_trap: got %h want %h", pack_b(), outs(T_ERR));
    end
  endtask

  task automatic test_halt();
    st_e seq[$];
    bit  mr[$];
    st_e e;
    seq = '{T_IF2, T_UPC, T_DEC, T_HALT, T_HALT, T_HALT, T_HALT};
    mr  = '{1'b1,  1'b1,  1'b1,  1'b1,   1'b0,   1'b1,   1'b0};
    opcode = 3'b111; op = 2'b00;
    for (int i = 0; i < seq.size(); i++) begin
      drive(mr[i], seq[i]);
      e = exp_q.pop_front();
      total++;
      if (pack_a() !== outs(e)) begin
        bad++; $display("[TB] FAIL halt step %0d (%s): got %h want %h", i, e.name(), pack_a(), outs(e));
      end
    end
    // Reset pulse lands between edges; RST must show before the next rising edge.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (pack_a() !== outs(T_RST)) begin
      bad++; $display("[TB] FAIL halt_async_reset: got %h want %h", pack_a(), outs(T_RST));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, T_IF1);
    e = exp_q.pop_front();
    total++;
    if (pack_a() !== outs(e)) begin
      bad++; $display("[TB] FAIL halt_restart (%s): got %h want %h", e.name(), pack_a(), outs(e));
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_back_to_back();
    test_ldr_wait();
    test_str_timeout();
    test_illegal();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
